// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD frame collection path.
package bcd_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2,
    ERR     = 2'd3
  } collector_state_t;

  // Smallest width w with 2^w > 10^digits - 1.
  function automatic int unsigned bin_width(input int unsigned digits);
    longint unsigned max_val;
    int unsigned     w;
    max_val = 1;
    for (int unsigned i = 0; i < digits; i++) begin
      max_val = max_val * 10;
    end
    max_val = max_val - 1;
    w = 1;
    while ((64'd1 << w) <= max_val) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/bcd_mac10.sv
// Combinational decimal multiply-accumulate: acc*10 + digit, built from shifts.
module bcd_mac10
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W = 14
) (
  input  logic [BIN_W-1:0]       acc,
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BIN_W-1:0]       result
);

  always_comb begin
    result = (acc << 3) + (acc << 1) + BIN_W'(digit);
  end

endmodule

// File: rtl/bcd_frame_collector.sv
// Assembles DIGITS converted BCD digits into a packed frame plus binary value,
// holding it for a ready/ack consumer and flagging frames hit by invalid codes.
module bcd_frame_collector
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned BIN_W  = 14
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_strobe,
  input  logic                          in_valid,
  input  logic [BCD_DIGIT_W-1:0]        in_digit,
  input  logic                          frame_ack,
  output logic                          out_ready,
  output logic                          out_err,
  output logic [BCD_DIGIT_W*DIGITS-1:0] out_bcd,
  output logic [BIN_W-1:0]              out_bin,
  output logic [3:0]                    digit_cnt
);

  localparam int unsigned BCD_W     = BCD_DIGIT_W * DIGITS;
  localparam logic [3:0]  DIGITS_C  = 4'(DIGITS);

  collector_state_t   state_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [BIN_W-1:0]   bin_q;
  logic [3:0]         cnt_q;
  logic               ready_q;
  logic               err_q;

  logic               open_w;
  logic               restart_w;
  logic [BCD_W-1:0]   base_bcd_d;
  logic [BIN_W-1:0]   base_bin_d;
  logic [3:0]         base_cnt_d;
  logic [BCD_W-1:0]   bcd_d;
  logic [BIN_W-1:0]   bin_d;
  logic [3:0]         cnt_d;

  // An ack in FULL/ERR clears the frame in the same cycle a new digit may land,
  // so the accumulate path works from the cleared base rather than the held value.
  always_comb begin
    open_w     = (state_q == IDLE) || (state_q == COLLECT);
    restart_w  = ((state_q == FULL) || (state_q == ERR)) && frame_ack;
    base_bcd_d = restart_w ? '0 : bcd_q;
    base_bin_d = restart_w ? '0 : bin_q;
    base_cnt_d = restart_w ? '0 : cnt_q;
    bcd_d      = (base_bcd_d << BCD_DIGIT_W) | BCD_W'(in_digit);
    cnt_d      = base_cnt_d + 4'd1;
  end

  bcd_mac10 #(
    .BIN_W (BIN_W)
  ) u_mac10 (
    .acc    (base_bin_d),
    .digit  (in_digit),
    .result (bin_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bcd_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (open_w || restart_w) begin
      bcd_q   <= base_bcd_d;
      bin_q   <= base_bin_d;
      cnt_q   <= base_cnt_d;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      state_q <= restart_w ? IDLE : state_q;
      if (in_strobe && in_valid) begin
        bcd_q <= bcd_d;
        bin_q <= bin_d;
        cnt_q <= cnt_d;
        if (cnt_d == DIGITS_C) begin
          state_q <= FULL;
          ready_q <= 1'b1;
        end else begin
          state_q <= COLLECT;
        end
      end else if (in_strobe) begin
        state_q <= ERR;
        err_q   <= 1'b1;
      end
    end
  end

  always_comb begin
    out_ready = ready_q;
    out_err   = err_q;
    out_bcd   = bcd_q;
    out_bin   = bin_q;
    digit_cnt = cnt_q;
  end

endmodule

// File: tb/tb_bcd_frame_collector.sv
// Directed checks of bcd_frame_collector at DIGITS=4 and DIGITS=1.
module tb_bcd_frame_collector;

  localparam int unsigned BIN_W1 = bcd_pkg::bin_width(1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        s0 = 0, v0 = 0, a0 = 0;
  logic [3:0]  d0 = '0;
  logic        rdy0, err0;
  logic [15:0] bcd0;
  logic [13:0] bin0;
  logic [3:0]  cnt0;

  logic        s1 = 0, v1 = 0, a1 = 0;
  logic [3:0]  d1 = '0;
  logic        rdy1, err1;
  logic [3:0]  bcd1;
  logic [BIN_W1-1:0] bin1;
  logic [3:0]  cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_frame_collector #(.DIGITS(4), .BIN_W(14)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_strobe(s0), .in_valid(v0), .in_digit(d0),
    .frame_ack(a0), .out_ready(rdy0), .out_err(err0), .out_bcd(bcd0),
    .out_bin(bin0), .digit_cnt(cnt0)
  );

  bcd_frame_collector #(.DIGITS(1), .BIN_W(BIN_W1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_strobe(s1), .in_valid(v1), .in_digit(d1),
    .frame_ack(a1), .out_ready(rdy1), .out_err(err1), .out_bcd(bcd1),
    .out_bin(bin1), .digit_cnt(cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc4(input logic s, input logic v, input logic [3:0] d, input logic a);
    s0 = s; v0 = v; d0 = d; a0 = a;
    @(posedge clk);
    #1;
    s0 = 0; v0 = 0; d0 = '0; a0 = 0;
  endtask

  task automatic cyc1(input logic s, input logic v, input logic [3:0] d, input logic a);
    s1 = s; v1 = v; d1 = d; a1 = a;
    @(posedge clk);
    #1;
    s1 = 0; v1 = 0; d1 = '0; a1 = 0;
  endtask

  task automatic out4(input string tag, input logic r, input logic e,
                      input logic [15:0] b, input logic [13:0] n, input logic [3:0] c);
    chk({tag, ".ready"}, 32'(rdy0), 32'(r));
    chk({tag, ".err"},   32'(err0), 32'(e));
    chk({tag, ".bcd"},   32'(bcd0), 32'(b));
    chk({tag, ".bin"},   32'(bin0), 32'(n));
    chk({tag, ".cnt"},   32'(cnt0), 32'(c));
  endtask

  initial begin
    #12;
    out4("reset", 0, 0, 16'h0000, 14'd0, 4'd0);
    chk("reset1.bcd", 32'(bcd1), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: digits 1,2,3,4
    cyc4(1, 1, 4'd1, 0);
    cyc4(1, 1, 4'd2, 0);
    cyc4(1, 1, 4'd3, 0);
    out4("t1_3dig", 0, 0, 16'h0123, 14'd123, 4'd3);
    cyc4(1, 1, 4'd4, 0);
    out4("t1_full", 1, 0, 16'h1234, 14'd1234, 4'd4);
    cyc4(0, 0, 4'd0, 1);
    out4("t1_ack", 0, 0, 16'h0000, 14'd0, 4'd0);

    // 2: digits 0,5 then invalid code
    cyc4(1, 1, 4'd0, 0);
    cyc4(1, 1, 4'd5, 0);
    cyc4(1, 0, 4'd1, 0);
    out4("t2_err", 0, 1, 16'h0005, 14'd5, 4'd2);
    cyc4(1, 1, 4'd6, 0);
    out4("t2_err_drop", 0, 1, 16'h0005, 14'd5, 4'd2);
    cyc4(0, 0, 4'd0, 1);
    out4("t2_ack", 0, 0, 16'h0000, 14'd0, 4'd0);

    // 3: 9999 and dropped strobes while FULL
    for (int i = 0; i < 4; i++) cyc4(1, 1, 4'd9, 0);
    out4("t3_full", 1, 0, 16'h9999, 14'd9999, 4'd4);
    cyc4(1, 1, 4'd3, 0);
    cyc4(1, 0, 4'd2, 0);
    out4("t3_drop", 1, 0, 16'h9999, 14'd9999, 4'd4);

    // 4: ack plus new first digit; ack ignored while collecting
    cyc4(1, 1, 4'd7, 1);
    out4("t4_restart", 0, 0, 16'h0007, 14'd7, 4'd1);
    cyc4(1, 1, 4'd8, 0);
    cyc4(1, 1, 4'd9, 1);
    out4("t4_ack_ignored", 0, 0, 16'h0789, 14'd789, 4'd3);
    cyc4(1, 1, 4'd1, 1);
    out4("t4_full", 1, 0, 16'h7891, 14'd7891, 4'd4);
    cyc4(1, 1, 4'd2, 1);
    out4("t4_b2b", 0, 0, 16'h0002, 14'd2, 4'd1);

    // 5: async reset between edges
    cyc4(1, 1, 4'd3, 0);
    out4("t5_pre", 0, 0, 16'h0023, 14'd23, 4'd2);
    #3 rst_n = 1'b0;
    #1;
    out4("t5_async", 0, 0, 16'h0000, 14'd0, 4'd0);
    #2 rst_n = 1'b1;
    cyc4(1, 1, 4'd5, 0);
    out4("t5_fresh", 0, 0, 16'h0005, 14'd5, 4'd1);

    // 6: DIGITS=1
    cyc1(1, 1, 4'd6, 0);
    chk("t6_ready", 32'(rdy1), 32'd1);
    chk("t6_bcd",   32'(bcd1), 32'h6);
    chk("t6_bin",   32'(bin1), 32'd6);
    chk("t6_cnt",   32'(cnt1), 32'd1);
    cyc1(1, 0, 4'hD, 1);
    chk("t6_err",       32'(err1), 32'd1);
    chk("t6_err_ready", 32'(rdy1), 32'd0);
    chk("t6_err_bcd",   32'(bcd1), 32'h0);
    chk("t6_err_cnt",   32'(cnt1), 32'd0);
    cyc1(1, 1, 4'd3, 1);
    chk("t6_re_ready", 32'(rdy1), 32'd1);
    chk("t6_re_err",   32'(err1), 32'd0);
    chk("t6_re_bcd",   32'(bcd1), 32'h3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_frame_collector.md
# bcd_frame_collector

Sequential stage directly downstream of the excess-3 to BCD converter. Each cycle it can accept one converted digit (`in_digit`) with the converter's `in_valid` flag. It assembles `DIGITS` consecutive valid digits into a packed BCD frame plus its binary equivalent. It then holds the frame for a consumer with a ready/ack handshake, and flags any frame that contained a non-excess-3 code.

## Interface
- `DIGITS`, default 4: digits per frame, range 1..8.
- `BIN_W`, default 14: width of the binary result; must satisfy 2^BIN_W > 10^DIGITS - 1.
- `clk`  in  1: sole clock; all state updates on rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_strobe`  in  1: a code is presented this cycle.
- `in_valid`  in  1: converter valid flag for the presented code.
- `in_digit`  in  4: BCD digit from the converter; meaningful only when `in_valid`=1.
- `frame_ack`  in  1: consumer accepts the held frame or error.
- `out_ready`  out  1: complete, error-free frame held.
- `out_err`  out  1: frame aborted by an invalid code.
- `out_bcd`  out  4*DIGITS: packed BCD. The first digit received is most significant.
- `out_bin`  out  BIN_W: binary value of `out_bcd`.
- `digit_cnt`  out  4: digits accepted into the current frame.

## Operation
- States: IDLE, COLLECT, FULL, ERR.
- Digit accept:
  - Taken when `in_strobe`=1 and `in_valid`=1 in IDLE or COLLECT.
  - Update: `out_bcd` <= {`out_bcd`[4*DIGITS-5:0], `in_digit`}; `out_bin` <= `out_bin`*10 + `in_digit` (BIN_W wide, no overflow by construction); `digit_cnt` += 1.
- IDLE:
  - Digit accept with no prior content goes to COLLECT; `out_bcd`/`out_bin` are zero on entry, so the first digit lands cleanly.
  - If DIGITS=1, the first accept goes directly to FULL.
- COLLECT:
  - When the accept makes `digit_cnt` reach DIGITS, go to FULL.
  - No strobe: hold.
- Invalid code:
  - `in_strobe`=1 with `in_valid`=0 in IDLE or COLLECT goes to ERR.
  - `out_bcd`, `out_bin` and `digit_cnt` keep their pre-error values; the bad code is not stored.
- FULL: `out_ready`=1. Strobes are dropped, not queued, not counted, and cause no error.
- ERR: `out_err`=1. Strobes are dropped.
- `frame_ack` in FULL or ERR:
  - Clears `out_bcd`, `out_bin` and `digit_cnt` and returns to IDLE.
  - If `in_strobe`=1 in the same cycle:
    - With `in_valid`=1, the digit becomes the first digit of the new frame: COLLECT, `digit_cnt`=1, or FULL when DIGITS=1.
    - With `in_valid`=0, go to ERR with cleared data.
- `frame_ack` in IDLE or COLLECT is ignored.
- Reset values: state IDLE; `out_ready`=0, `out_err`=0, `out_bcd`=0, `out_bin`=0, `digit_cnt`=0. Reset mid-frame discards partial data with no residue.

## Timing
- All outputs are registered. They change only on a `clk` rising edge or on `rst_n` assertion.
- Strobe to state/output update latency: 1 cycle.
- `out_ready` and `out_err` rise the cycle after the completing or invalid strobe. They stay high until the edge on which `frame_ack` is sampled and fall on that edge.
- Back-to-back strobes every cycle are supported; a frame completes DIGITS cycles after its first accepted strobe.
- Maximum throughput with an ack in the same cycle as the next first digit: one frame every DIGITS cycles.
- `out_ready` and `out_err` are mutually exclusive at all times.

## Structure
- Shared package `bcd_pkg`:
  - State enum `collector_state_t` (IDLE, COLLECT, FULL, ERR).
  - Constant `BCD_DIGIT_W`=4.
  - Function `bin_width(digits)` returning the minimum BIN_W.
- One natural sub-module, `bcd_mac10`, combinational: `acc`*10 + `digit` at width BIN_W, implemented as (`acc`<<3)+(`acc`<<1)+`digit`. It is instantiated once.
- The converter stays a separate instance upstream; this block does not re-decode excess-3.

## Test plan
1. DIGITS=4. Excess-3 codes 4'h4, 4'h5, 4'h6, 4'h7 on consecutive strobes. Expect `out_ready`=1 one cycle after the 4th, `out_bcd`=16'h1234, `out_bin`=1234, `digit_cnt`=4. `frame_ack` then gives all outputs 0 next cycle.
2. Codes 4'h3, 4'h8, then 4'h1 (converter `in_valid`=0). Expect ERR: `out_err`=1, `out_bcd`=16'h0005, `digit_cnt`=2, `out_ready`=0. `frame_ack` returns to IDLE with outputs zeroed.
3. Full frame 9,9,9,9 (codes 4'hC). Expect `out_bin`=9999 with no overflow at BIN_W=14. Extra strobes while FULL leave `out_bcd`=16'h9999 and `digit_cnt`=4 unchanged.
4. In FULL, assert `frame_ack` and strobe digit 7 in the same cycle. Next cycle: state COLLECT, `digit_cnt`=1, `out_bcd`=16'h0007, `out_bin`=7, `out_ready`=0.
5. Assert `rst_n`=0 asynchronously between clock edges after 2 digits. All outputs go to 0 immediately. After release, the first strobe starts a fresh frame with `digit_cnt`=1.
6. DIGITS=1. A single strobe of digit 6 gives `out_ready`=1 and `out_bcd`=4'h6 one cycle later. A `frame_ack` plus a strobe of invalid code 4'hD gives `out_err`=1.
